// File: rtl/shift_pkg.sv
// Shared definitions for the shift sweep sequencer: mode codes and FSM states.
package shift_pkg;

  localparam logic [1:0] MODE_LLS = 2'b00;
  localparam logic [1:0] MODE_RLS = 2'b01;
  localparam logic [1:0] MODE_LAS = 2'b10;
  localparam logic [1:0] MODE_RAS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_unit.sv
// Combinational shift datapath (LLS/RLS/LAS/RAS).
// Optional macro SHIFT_SWEEP_ROTATE_EN turns mode 10 into rotate-left;
// without it mode 10 behaves exactly like LLS.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int AMT_W = 3
) (
  input  logic [WIDTH-1:0] op,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] res
);

`ifdef SHIFT_SWEEP_ROTATE_EN
  // Rotating a doubled copy leaves the rotated word in the upper half.
  logic [2*WIDTH-1:0] w_dbl;
  assign w_dbl = {op, op} << (int'(amt) % WIDTH);
`endif

  // Select the shift flavour; shifts by >= WIDTH naturally give 0 / sign fill.
  always_comb begin
    res = op << amt;
    case (mode)
      MODE_RLS: res = op >> amt;
      MODE_RAS: res = $unsigned($signed(op) >>> amt);
`ifdef SHIFT_SWEEP_ROTATE_EN
      MODE_LAS: res = w_dbl[2*WIDTH-1:WIDTH];
`endif
      default:  res = op << amt;
    endcase
  end

endmodule

// File: rtl/shift_sweep_ctrl.sv
// Sweep sequencer: latches one operand and streams shift(op, mode, 0..max_amt)
// over a valid/ready port, then pulses done. Owns the single shift_unit.
// Optional macro SHIFT_SWEEP_ROTATE_EN (handled inside shift_unit).
module shift_sweep_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] max_amt,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AMT_W-1:0] out_amt,
  output logic             done
);

  state_t           r_state;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_op;
  logic [AMT_W-1:0] r_max;
  logic [AMT_W-1:0] r_amt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_sh_op;
  logic [1:0]       w_sh_mode;
  logic [AMT_W-1:0] w_sh_amt;
  logic [WIDTH-1:0] w_sh_res;
  logic             w_xfer;

  // In IDLE the datapath sees the live command (amount 0); in RUN it
  // precomputes the next beat so consecutive transfers need no bubble.
  assign w_sh_op   = (r_state == ST_IDLE) ? din  : r_op;
  assign w_sh_mode = (r_state == ST_IDLE) ? mode : r_mode;
  assign w_sh_amt  = (r_state == ST_IDLE) ? '0   : r_amt + AMT_W'(1);
  assign w_xfer    = r_valid && out_ready;

  shift_unit #(
    .WIDTH(WIDTH),
    .AMT_W(AMT_W)
  ) u_shift (
    .op  (w_sh_op),
    .mode(w_sh_mode),
    .amt (w_sh_amt),
    .res (w_sh_res)
  );

  // Sweep FSM with registered outputs; abort outranks a same-cycle transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_LLS;
      r_op    <= '0;
      r_max   <= '0;
      r_amt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mode  <= mode;
            r_op    <= din;
            r_max   <= max_amt;
            r_amt   <= '0;
            r_data  <= w_sh_res;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_xfer) begin
            if (r_amt == r_max) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_amt  <= r_amt + AMT_W'(1);
              r_data <= w_sh_res;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_amt   = r_amt;
  assign done      = r_done;

endmodule

// File: tb/tb_shift_sweep_ctrl.sv
// Scoreboard bench for shift_sweep_ctrl: stimulus pushes expected beats,
// a negedge monitor compares every presented beat and done pulse.
module tb_shift_sweep_ctrl;

  localparam int WIDTH = 5;
  localparam int AMT_W = 3;
  localparam int MODV  = 1 << WIDTH;
  localparam int HALF  = MODV / 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] din = '0;
  logic [AMT_W-1:0] max_amt = '0;
  logic             abort = 1'b0;
  logic             busy;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [AMT_W-1:0] out_amt;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit is_done;
    int data;
    int amt;
  } exp_t;

  exp_t exp_q[$];

  shift_sweep_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .din      (din),
    .max_amt  (max_amt),
    .abort    (abort),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_amt  (out_amt),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: apply a one-bit step n times using plain arithmetic.
  function automatic int ref_shift(input int op, input int m, input int n);
    int v;
    v = op;
    for (int i = 0; i < n; i++) begin
      case (m)
        0: v = (v * 2) % MODV;
        1: v = v / 2;
`ifdef SHIFT_SWEEP_ROTATE_EN
        2: v = (v * 2) % MODV + v / HALF;
`else
        2: v = (v * 2) % MODV;
`endif
        default: v = v / 2 + ((v >= HALF) ? HALF : 0);
      endcase
    end
    return v;
  endfunction

  // Monitor: compare whatever the DUT presents against the queue front.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        chk("busy_with_valid", int'(busy), 1);
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          chk("out_data", int'(out_data), exp_q[0].data);
          chk("out_amt", int'(out_amt), exp_q[0].amt);
          if (out_ready && !abort) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        chk("busy_with_done", int'(busy), 1);
        if (exp_q.size() == 0 || !exp_q[0].is_done) chk("unexpected_done", 1, 0);
        else void'(exp_q.pop_front());
      end
    end
  end

  // One sweep; rdy_style 0=always, 1=alternating from 1, 2=random.
  task automatic do_sweep(input int m, input int d, input int mx, input int abort_at,
                          input int rdy_style, input bit extra_start);
    int  c;
    int  n_xfer;
    bit  finished;
    bit  rdy;
    exp_t e;
    for (int k = 0; k <= mx; k++) begin
      e.is_done = 1'b0; e.data = ref_shift(d, m, k); e.amt = k;
      exp_q.push_back(e);
    end
    e.is_done = 1'b1; e.data = 0; e.amt = 0;
    exp_q.push_back(e);
    $display("sweep mode=%0d din=%0d max=%0d abort_at=%0d ready=%0d", m, d, mx, abort_at, rdy_style);
    mode = 2'(m); din = WIDTH'(d); max_amt = AMT_W'(mx); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom); din = WIDTH'($urandom); max_amt = AMT_W'($urandom);
    c = 0; n_xfer = 0; finished = 1'b0;
    while (!finished) begin
      if (c >= 200) begin
        chk("sweep_timeout", c, 0);
        exp_q.delete();
        break;
      end
      start = 1'b0;
      if (extra_start && (c % 2 == 1)) begin
        start = 1'b1; din = WIDTH'($urandom); mode = 2'($urandom); max_amt = AMT_W'($urandom);
      end
      chk("valid_in_run", int'(out_valid), 1);
      if (abort_at >= 0 && n_xfer == abort_at) begin
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        exp_q.delete();
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(posedge clk); #1;
        chk("abort_no_done", int'(done), 0);
        finished = 1'b1;
      end else begin
        case (rdy_style)
          0: rdy = 1'b1;
          1: rdy = (c % 2 == 0);
          default: rdy = ($urandom_range(99) < 60);
        endcase
        out_ready = rdy;
        @(posedge clk); #1;
        if (rdy) n_xfer++;
        if (n_xfer == mx + 1) begin
          start = 1'b0; out_ready = 1'($urandom);
          chk("done_pulse", int'(done), 1);
          chk("done_valid_low", int'(out_valid), 0);
          chk("done_busy", int'(busy), 1);
          @(posedge clk); #1;
          chk("idle_done_low", int'(done), 0);
          chk("idle_busy_low", int'(busy), 0);
          chk("queue_drained", exp_q.size(), 0);
          finished = 1'b1;
        end
      end
      c++;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  // Async reset mid-RUN at amt=2, then a normal sweep.
  task automatic do_reset_mid();
    exp_t e;
    for (int k = 0; k <= 7; k++) begin
      e.is_done = 1'b0; e.data = ref_shift(20, 0, k); e.amt = k;
      exp_q.push_back(e);
    end
    $display("reset mid-run test");
    mode = 2'b00; din = 5'b10100; max_amt = 3'd7; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_reset_amt", int'(out_amt), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_amt", int'(out_amt), 0);
    chk("rst_done", int'(done), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_data", int'(out_data), 0);
    chk("reset_amt", int'(out_amt), 0);
    chk("reset_done", int'(done), 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_sweep(1, 20, 2, -1, 0, 1'b0);
    do_sweep(3, 20, 7, -1, 0, 1'b0);
    do_sweep(0, 20, 3, -1, 1, 1'b0);
    do_sweep(0, 20, 4, 1, 0, 1'b1);
    do_reset_mid();
    do_sweep(2, 20, 5, -1, 0, 1'b0);
    do_sweep(2, 20, 2, -1, 0, 1'b0);
    do_sweep(3, 13, 0, -1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int mx;
      int ab;
      mx = $urandom_range(7);
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(mx)) : -1;
      do_sweep($urandom_range(3), $urandom_range(MODV - 1), mx, ab, 2, 1'($urandom));
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
    end

    @(posedge clk); #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_sweep_ctrl.md
Name: shift_sweep_ctrl

Overview:
Sequencer for the team's shift unit (LLS/RLS/LAS/RAS). It accepts one operand, a shift mode and a maximum shift amount. It then sweeps the amount from 0 to the maximum and emits one shifted result per beat over a valid/ready stream. It sits between a command source (CPU register, test FSM) and a result consumer (display, capture FIFO), and owns the only instance of the shift datapath.

Parameters:
WIDTH, 5, operand/result width in bits
AMT_W, 3, shift-amount width; max_amt may exceed WIDTH-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe; accepted only in IDLE
mode  in  2  00 LLS, 01 RLS, 10 LAS, 11 RAS
din  in  WIDTH  operand
max_amt  in  AMT_W  last shift amount of the sweep (inclusive)
abort  in  1  cancel an active sweep
busy  out  1  high in RUN and DONE
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts beat
out_data  out  WIDTH  shifted result, registered
out_amt  out  AMT_W  shift amount of the current beat, registered
done  out  1  one-cycle pulse after the final beat

Behaviour:
- Clock and reset: one clock `clk`; asynchronous active-low reset `rst_n`.
- Reset: state=IDLE; busy, out_valid, out_data, out_amt, done all 0. Reset takes effect immediately, mid-sweep included; the sweep in progress is lost.
- States: IDLE, RUN, DONE (2-bit encoding from the package).
- IDLE:
  - start=1 at an edge: latch mode, din and max_amt; amt=0; out_data=shift(din,mode,0)=din; go to RUN.
  - out_valid is high in the cycle after the start edge (1-cycle latency).
- RUN:
  - out_valid=1 and busy=1.
  - Beat transfer = out_valid && out_ready at an edge.
  - Transfer with amt<max_amt: amt+1; out_data=shift(op,mode,amt+1), updated at the same edge, so back-to-back beats need no bubble.
  - Transfer with amt==max_amt: go to DONE; out_valid=0.
  - out_ready=0: out_data and out_amt hold stable.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. done is low in every other state.
- abort:
  - Effective only in RUN; it has priority over a same-cycle transfer.
  - Next edge: IDLE, out_valid=0, no done pulse. out_data and out_amt keep their last values.
  - Ignored in IDLE and DONE.
- start while busy: ignored. Latched operands never change mid-sweep.
- max_amt=0: single beat (din), then DONE.
- Shift semantics (op = latched din, n = amt):
  - LLS and LAS: op<<n, zero fill.
  - RLS: op>>n, zero fill.
  - RAS: signed right shift, filled with op[WIDTH-1].
  - n>=WIDTH: LLS/LAS/RLS give 0; RAS gives all copies of the sign bit.
  - Results are truncated to WIDTH bits. amt never wraps, because the sweep stops at max_amt.

Optional Feature:
SHIFT_SWEEP_ROTATE_EN
- Defined: mode 10 becomes rotate-left, (op<<(n mod WIDTH)) | (op>>(WIDTH-(n mod WIDTH))), masked to WIDTH bits.
- Undefined: mode 10 is LAS, identical to LLS.
- All other modes are unchanged in both builds.

Decomposition:
- Shared package shift_pkg:
  - mode constants: MODE_LLS=2'b00, MODE_RLS=2'b01, MODE_LAS=2'b10, MODE_RAS=2'b11
  - state encodings: ST_IDLE, ST_RUN, ST_DONE
- One sub-module, shift_unit:
  - purely combinational
  - parameters WIDTH, AMT_W
  - inputs op, mode, amt; output res
  - the rotate option is implemented inside it
- shift_sweep_ctrl holds the FSM, operand latches, the amount counter and the output registers.

Test Plan:
1. RLS, din=10100, max_amt=2, out_ready=1 → beats 10100/01010/00101 with out_amt 0/1/2 on consecutive cycles; done one cycle later; busy low after that.
2. RAS, din=10100, max_amt=7 → 10100, 11010, 11101, 11110, 11111, 11111, 11111, 11111; done after the 8th beat.
3. LLS, din=10100, max_amt=3, out_ready pattern 1,0,1,0,1,0,1 → data held during each 0 cycle; beats 10100/01000/10000/00000; exactly 4 transfers, 1 done.
4. Abort: start, then abort=1 at amt=1 together with out_ready=1 → next cycle out_valid=0, busy=0, no done. A second start pulse during RUN is ignored (out_amt sequence unaffected).
5. rst_n=0 asynchronously mid-RUN (amt=2) → out_valid, busy, out_data, out_amt and done go to 0 before the next clock edge; a fresh start after release sweeps normally.
6. mode=10, din=10100, max_amt=2:
   - with SHIFT_SWEEP_ROTATE_EN → 10100/01001/10010
   - without it → 10100/01000/10000
